alu_apb_sequencer: RTL and testbench

- Two-requester front end for the ALU's APB slave port.
- Arbitrates round-robin between two command sources and issues one APB write of the 32-bit command word to the ALU.
- Then issues one APB read of the result register and returns the result (or an error) to the granted requester.
- Sits between the ALU and its command sources, which are the sequencer/CPU side and the debug side.

---
 rtl/alu_apb_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_apb_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_apb_sequencer.sv
//==============================================================================
// Module : alu_apb_sequencer
// Desc   : Round-robin front end for two command sources; issues one APB write
//          of the command word, one APB read of the result, then a response.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_apb_sequencer #(
    parameter logic [31:0] CMD_ADDR = 32'h0000_0000,
    parameter logic [31:0] RES_ADDR = 32'h0000_0004,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_ACCESS = 3'd2,
        RD_SETUP  = 3'd3,
        RD_ACCESS = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_last_grant, w_last_grant_nxt;
    logic        r_owner, w_owner_nxt;
    logic [31:0] r_cmd, w_cmd_nxt;
    logic [7:0]  r_tcnt, w_tcnt_nxt;
    logic        r_psel, w_psel_nxt;
    logic        r_penable, w_penable_nxt;
    logic        r_pwrite, w_pwrite_nxt;
    logic [31:0] r_paddr, w_paddr_nxt;
    logic [31:0] r_pwdata, w_pwdata_nxt;
    logic        r_rsp0_valid, w_rsp0_valid_nxt;
    logic [31:0] r_rsp0_data, w_rsp0_data_nxt;
    logic        r_rsp0_err, w_rsp0_err_nxt;
    logic        r_rsp1_valid, w_rsp1_valid_nxt;
    logic [31:0] r_rsp1_data, w_rsp1_data_nxt;
    logic        r_rsp1_err, w_rsp1_err_nxt;
    logic        w_grant0, w_grant1;
    logic        w_done;
    logic [31:0] w_done_data;
    logic        w_done_err;

    // On contention the requester that did not win last time is preferred.
    assign w_grant0 = (r_state == IDLE) && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = (r_state == IDLE) && req1_valid && (!req0_valid || !r_last_grant);

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_owner_nxt      = r_owner;
        w_cmd_nxt        = r_cmd;
        w_tcnt_nxt       = r_tcnt;
        w_psel_nxt       = 1'b0;
        w_penable_nxt    = 1'b0;
        w_pwrite_nxt     = 1'b0;
        w_paddr_nxt      = 32'h0;
        w_pwdata_nxt     = 32'h0;
        w_done           = 1'b0;
        w_done_data      = 32'h0;
        w_done_err       = 1'b0;

        // APB outputs are registered, so each branch loads the values of the
        // state being entered.
        case (r_state)
            IDLE: begin
                if (w_grant0 || w_grant1) begin
                    w_owner_nxt      = w_grant1;
                    w_last_grant_nxt = w_grant1;
                    w_cmd_nxt        = w_grant1 ? req1_data : req0_data;
                    w_state_nxt      = WR_SETUP;
                    w_psel_nxt       = 1'b1;
                    w_pwrite_nxt     = 1'b1;
                    w_paddr_nxt      = CMD_ADDR;
                    w_pwdata_nxt     = w_grant1 ? req1_data : req0_data;
                end
            end
            WR_SETUP: begin
                w_state_nxt   = WR_ACCESS;
                w_tcnt_nxt    = 8'd0;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_pwrite_nxt  = 1'b1;
                w_paddr_nxt   = CMD_ADDR;
                w_pwdata_nxt  = r_cmd;
            end
            WR_ACCESS: begin
                if (pready && !pslverr) begin
                    w_state_nxt = RD_SETUP;
                    w_psel_nxt  = 1'b1;
                    w_paddr_nxt = RES_ADDR;
                end else if (pready || (r_tcnt == C_TMO_LAST)) begin
                    w_state_nxt = RESP;
                    w_done      = 1'b1;
                    w_done_err  = 1'b1;
                end else begin
                    w_tcnt_nxt    = r_tcnt + 8'd1;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                    w_pwrite_nxt  = 1'b1;
                    w_paddr_nxt   = CMD_ADDR;
                    w_pwdata_nxt  = r_cmd;
                end
            end
            RD_SETUP: begin
                w_state_nxt   = RD_ACCESS;
                w_tcnt_nxt    = 8'd0;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_paddr_nxt   = RES_ADDR;
            end
            RD_ACCESS: begin
                if (pready) begin
                    w_state_nxt = RESP;
                    w_done      = 1'b1;
                    w_done_data = prdata;
                    w_done_err  = pslverr;
                end else if (r_tcnt == C_TMO_LAST) begin
                    w_state_nxt = RESP;
                    w_done      = 1'b1;
                    w_done_err  = 1'b1;
                end else begin
                    w_tcnt_nxt    = r_tcnt + 8'd1;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                    w_paddr_nxt   = RES_ADDR;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_rsp0_valid_nxt = w_done && !r_owner;
        w_rsp0_data_nxt  = (w_done && !r_owner) ? w_done_data : 32'h0;
        w_rsp0_err_nxt   = w_done && !r_owner && w_done_err;
        w_rsp1_valid_nxt = w_done && r_owner;
        w_rsp1_data_nxt  = (w_done && r_owner) ? w_done_data : 32'h0;
        w_rsp1_err_nxt   = w_done && r_owner && w_done_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cmd        <= 32'h0;
            r_tcnt       <= 8'd0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= 32'h0;
            r_pwdata     <= 32'h0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= 32'h0;
            r_rsp0_err   <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= 32'h0;
            r_rsp1_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_cmd        <= w_cmd_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_psel       <= w_psel_nxt;
            r_penable    <= w_penable_nxt;
            r_pwrite     <= w_pwrite_nxt;
            r_paddr      <= w_paddr_nxt;
            r_pwdata     <= w_pwdata_nxt;
            r_rsp0_valid <= w_rsp0_valid_nxt;
            r_rsp0_data  <= w_rsp0_data_nxt;
            r_rsp0_err   <= w_rsp0_err_nxt;
            r_rsp1_valid <= w_rsp1_valid_nxt;
            r_rsp1_data  <= w_rsp1_data_nxt;
            r_rsp1_err   <= w_rsp1_err_nxt;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign paddr      = r_paddr;
    assign pwdata     = r_pwdata;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp0_err   = r_rsp0_err;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_data  = r_rsp1_data;
    assign rsp1_err   = r_rsp1_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_apb_sequencer.sv
//==============================================================================
// Module : tb_alu_apb_sequencer
// Desc   : Self-checking bench: transaction-timing model plus randomized traffic.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_apb_sequencer;

    localparam int          TMO   = 16;
    localparam logic [31:0] CMD_A = 32'h0000_0000;
    localparam logic [31:0] RES_A = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_err;
    logic [31:0] req0_data, rsp0_data;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] req1_data, rsp1_data;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;

    alu_apb_sequencer #(.CMD_ADDR(CMD_A), .RES_ADDR(RES_A), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        psel, pen, pwr;
        logic [31:0] paddr, pwdata;
        logic        rv0, re0;
        logic [31:0] rd0;
        logic        rv1, re1;
        logic [31:0] rd1;
    } exp_t;

    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    exp_t        em[int];      // expected outputs per cycle; absent means idle
    logic [1:0]  erdy[int];    // expected {req1_ready, req0_ready} per cycle
    rsp_t        rlog[$];
    logic [31:0] wlog[$];

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;
    int          free_at = 0;
    bit          lg = 1'b1;
    bit          pend0 = 1'b0, pend1 = 1'b0;
    int          acc = 0;
    int          pl_ww = 0, pl_rw = 0;
    bit          pl_werr = 1'b0, pl_rerr = 1'b0;
    logic [31:0] pl_rdata = 32'h0;
    int          acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        while (cyc < free_at) tick();
    endtask

    task automatic put(input int k, input bit ps, input bit pe, input bit pw,
                       input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e = '0;
        e.psel = ps; e.pen = pe; e.pwr = pw; e.paddr = a; e.pwdata = wd;
        em[k] = e;
    endtask

    task automatic put_rsp(input int k, input bit own, input logic [31:0] d, input bit er);
        exp_t e;
        e = '0;
        if (own) begin e.rv1 = 1'b1; e.rd1 = d; e.re1 = er; end
        else     begin e.rv0 = 1'b1; e.rd0 = d; e.re0 = er; end
        em[k] = e;
        free_at = k + 1;
    endtask

    // Cycle n is the write SETUP cycle following the accepting edge.
    task automatic predict(input int n, input bit own, input logic [31:0] d);
        int a, b, t;
        put(n, 1, 0, 1, CMD_A, d);
        a = (pl_ww < TMO) ? pl_ww + 1 : TMO;
        for (int k = 1; k <= a; k++) put(n + k, 1, 1, 1, CMD_A, d);
        t = n + 1 + a;
        if (pl_ww >= TMO || pl_werr) begin
            put_rsp(t, own, 32'h0, 1'b1);
        end else begin
            put(t, 1, 0, 0, RES_A, 32'h0);
            b = (pl_rw < TMO) ? pl_rw + 1 : TMO;
            for (int k = 1; k <= b; k++) put(t + k, 1, 1, 0, RES_A, 32'h0);
            if (pl_rw < TMO) put_rsp(t + 1 + b, own, pl_rdata, pl_rerr);
            else             put_rsp(t + 1 + b, own, 32'h0, 1'b1);
        end
    endtask

    task automatic issue(input bit w0, input bit w1, input logic [31:0] a0, input logic [31:0] a1,
                         input int ww, input bit werr, input int rw, input bit rerr,
                         input logic [31:0] rd);
        bit g;
        if (w0 && !pend0) begin pend0 = 1'b1; req0_valid = 1'b1; req0_data = a0; end
        if (w1 && !pend1) begin pend1 = 1'b1; req1_valid = 1'b1; req1_data = a1; end
        if (!pend0 && !pend1) return;
        wait_free();
        g = (pend0 && pend1) ? ~lg : pend1;
        erdy[cyc] = g ? 2'b10 : 2'b01;
        pl_ww = ww; pl_werr = werr; pl_rw = rw; pl_rerr = rerr; pl_rdata = rd;
        predict(cyc + 1, g, g ? req1_data : req0_data);
        lg  = g;
        acc = cyc + 1;
        tick();
        if (g) begin pend1 = 1'b0; req1_valid = 1'b0; end
        else   begin pend0 = 1'b0; req0_valid = 1'b0; end
    endtask

    task automatic chk_rsp(input string nm, input int idx, input bit port, input int off,
                           input logic [31:0] d, input bit er);
        if (rlog.size() <= idx) chk({nm, "_count"}, rlog.size(), idx + 1);
        else chk(nm, {rlog[idx].port, rlog[idx].cyc - acc, rlog[idx].data, rlog[idx].err},
                 {port, off, d, er});
    endtask

    // APB slave: waits per plan inside ACCESS, random junk everywhere else.
    always @(posedge clk) begin
        #1;
        if (psel && penable) begin
            pready  = (acc_cnt >= (pwrite ? pl_ww : pl_rw));
            pslverr = pready ? (pwrite ? pl_werr : pl_rerr) : 1'($urandom);
            prdata  = (pready && !pwrite) ? pl_rdata : $urandom;
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end
    end

    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] rr;
        if (chk_en) begin
            e  = em.exists(cyc) ? em[cyc] : '0;
            rr = erdy.exists(cyc) ? erdy[cyc] : 2'b00;
            chk("apb_ctl", {psel, penable, pwrite}, {e.psel, e.pen, e.pwr});
            chk("paddr", paddr, e.paddr);
            chk("pwdata", pwdata, e.pwdata);
            chk("rsp0", {rsp0_valid, rsp0_err, rsp0_data}, {e.rv0, e.re0, e.rd0});
            chk("rsp1", {rsp1_valid, rsp1_err, rsp1_data}, {e.rv1, e.re1, e.rd1});
            chk("ready", {req1_ready, req0_ready}, rr);
        end
        if (rsp0_valid === 1'b1) rlog.push_back(rsp_t'{cyc, 1'b0, rsp0_data, rsp0_err});
        if (rsp1_valid === 1'b1) rlog.push_back(rsp_t'{cyc, 1'b1, rsp1_data, rsp1_err});
        if (psel === 1'b1 && penable === 1'b0 && pwrite === 1'b1) wlog.push_back(pwdata);
    end

    initial begin
        int n, r, ww, rw;
        bit exp_seq[5];
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 32'h0; req1_data = 32'h0;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("reset_out", {psel, penable, pwrite, paddr, pwdata, rsp0_valid, rsp0_data,
                          rsp0_err, rsp1_valid, rsp1_data, rsp1_err}, '0);
        reset = 1'b0;
        free_at = cyc;

        n = rlog.size();
        issue(1, 0, 32'h6041C0C0, 32'h0, 0, 0, 0, 0, 32'h0000_1234);
        wait_free();
        chk_rsp("single_op", n, 1'b0, 4, 32'h0000_1234, 1'b0);
        chk("single_wdata", wlog[$], 32'h6041C0C0);
        chk("single_rsp_count", rlog.size(), n + 1);

        // Requester 0 won last, so contention starts with requester 1.
        n = rlog.size();
        repeat (4) issue(1, 1, $urandom, $urandom, 0, 0, 0, 0, $urandom);
        issue(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, $urandom);
        wait_free();
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        chk("contention_count", rlog.size(), n + 5);
        for (int i = 0; i < 5; i++)
            if (rlog.size() > n + i) chk("contention_grant", rlog[n + i].port, exp_seq[i]);

        n = rlog.size();
        issue(1, 0, $urandom, 32'h0, 3, 0, 3, 0, 32'hCAFE_0003);
        wait_free();
        chk_rsp("wait_states", n, 1'b0, 10, 32'hCAFE_0003, 1'b0);

        n = rlog.size();
        issue(0, 1, 32'h0, 32'h1111_2222, 0, 1, 0, 0, 32'hDEAD_BEEF);
        wait_free();
        chk_rsp("wr_err", n, 1'b1, 2, 32'h0, 1'b1);

        n = rlog.size();
        issue(1, 0, 32'h3333_4444, 32'h0, 0, 0, 1, 1, 32'hBAD0_0001);
        wait_free();
        chk_rsp("rd_err", n, 1'b0, 5, 32'hBAD0_0001, 1'b1);

        n = rlog.size();
        issue(0, 1, 32'h0, 32'h5555_6666, 16, 0, 0, 0, 32'h1);
        wait_free();
        chk_rsp("wr_timeout", n, 1'b1, 17, 32'h0, 1'b1);

        n = rlog.size();
        issue(1, 0, 32'h7777_8888, 32'h0, 15, 0, 0, 0, 32'h5A5A_5A5A);
        wait_free();
        chk_rsp("wr_tmo_minus1", n, 1'b0, 19, 32'h5A5A_5A5A, 1'b0);

        n = rlog.size();
        issue(0, 1, 32'h0, 32'h9999_AAAA, 0, 0, 16, 0, 32'h2);
        wait_free();
        chk_rsp("rd_timeout", n, 1'b1, 19, 32'h0, 1'b1);

        // Requester 0 raises and then withdraws valid while the bus is busy.
        n = rlog.size();
        issue(0, 1, 32'h0, $urandom, 0, 0, 3, 0, $urandom);
        tick();
        req0_valid = 1'b1; req0_data = $urandom;
        tick(); tick();
        req0_valid = 1'b0;
        wait_free();
        repeat (3) tick();
        chk("withdraw_count", rlog.size(), n + 1);

        // Reset while in the read ACCESS phase drops the command silently.
        issue(1, 0, $urandom, 32'h0, 0, 0, 5, 0, $urandom);
        while (cyc < acc + 4) tick();
        reset = 1'b1;
        r = cyc;
        for (int k = r + 1; k < free_at; k++) em.delete(k);
        tick();
        reset = 1'b0;
        lg = 1'b1;
        free_at = cyc;
        n = rlog.size();
        chk("reset_mid_out", {psel, penable, rsp0_valid, rsp1_valid}, 4'b0000);
        issue(1, 1, $urandom, $urandom, 0, 0, 0, 0, 32'h0000_0077);
        wait_free();
        chk_rsp("reset_then_grant0", n, 1'b0, 4, 32'h0000_0077, 1'b0);
        issue(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, $urandom);

        repeat (150) begin
            ww = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            rw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  ww, ($urandom_range(0, 7) == 0), rw, ($urandom_range(0, 7) == 0), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        while (pend0 || pend1) issue(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, $urandom);
        wait_free();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
